seq_det_ctrl: RTL and testbench
===============================

# seq_det_ctrl

Run controller and programmable serial pattern detector for the FSM sequence-detector family. It arms, runs and stops detection on a handshaked serial bit stream. It holds a software-loaded pattern (e.g. 1101) and an overlap/non-overlap mode, counts matches, and ends the run when a programmed match threshold is reached. It sits between a bit-stream source and the status/interrupt logic, and replaces hard-wired per-pattern detectors.

## Interface
- PAT_W, 4: pattern length in bits, legal 2..8
- CNT_W, 8: width of the match counter and threshold
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- cfg_we  in  1  load cfg_pat/cfg_ovl/cfg_thresh; honoured only in IDLE
- cfg_pat  in  PAT_W  pattern; MSB is the first bit in arrival order
- cfg_ovl  in  1  1 = overlapping detection, 0 = non-overlapping
- cfg_thresh  in  CNT_W  match count that ends the run; 0 = unlimited
- start  in  1  begin a run (IDLE or DONE)
- stop  in  1  abort a run (RUN or DONE)
- in_valid  in  1  in_bit is valid
- in_bit  in  1  serial data bit
- in_ready  out  1  controller accepts a bit; high only in RUN
- match  out  1  one-cycle pulse per detected pattern
- match_cnt  out  CNT_W  matches in the current or last run
- done  out  1  high while in DONE
- busy  out  1  high while in RUN
- state  out  2  IDLE=0, RUN=1, DONE=2; 3 unused and recovers to IDLE

## Operation
- A bit is accepted when in_valid && in_ready. Bits offered at any other time are dropped and have no effect.
- Config registers are loaded on cfg_we in IDLE and ignored in RUN or DONE. The detector always uses the registered config, never the live cfg_* inputs.
- Detector state:
  - hist is a PAT_W-bit shift register with the newest bit in the LSB.
  - fill counts valid history bits and saturates at PAT_W.
- On each accepted bit: hist' = {hist[PAT_W-2:0], in_bit} and fill' = min(fill+1, PAT_W).
- A match occurs when fill' == PAT_W and hist' == pat.
- After a match:
  - Overlap mode: fill stays at PAT_W, so a suffix of the match can start the next match.
  - Non-overlap mode: fill is cleared to 0 and hist is kept, so the next match needs PAT_W new bits.
- match_cnt increments on each match and saturates at 2^CNT_W-1.
- FSM transitions:
  - IDLE: start -> RUN; clears hist, fill and match_cnt.
  - RUN: stop -> IDLE. Otherwise, a match that makes match_cnt' == thresh (thresh != 0) -> DONE.
  - DONE: start -> RUN (clears as from IDLE); stop -> IDLE.
- Priority: stop over start when both are asserted the same cycle. stop in IDLE is a no-op.
- A bit accepted in the same cycle as stop is still evaluated: a match pulses and counts, then the FSM enters IDLE.
- A bit accepted in the same cycle as the threshold match is the last bit of the run.
- match_cnt holds its value in IDLE and DONE until the next start.
- Reset values:
  - state=IDLE, in_ready=0, match=0, match_cnt=0, done=0, busy=0
  - hist=0, fill=0
  - pat=0, ovl=1, thresh=0

## Timing
- All outputs are registered, except in_ready, busy and done, which decode the state register directly.
- A bit accepted at edge N produces match high for the cycle after edge N and match_cnt updated after edge N. Latency is 1 cycle.
- Threshold: the state is DONE after the same edge that registers the final match, so in_ready falls on the cycle match is high.
- start at edge N: busy and in_ready are high after N, and the first bit can be accepted at edge N+1.
- Back-to-back bits are accepted every cycle at full rate, with no bubble after a match in either mode.
- Reset assertion at any time, including mid-run, immediately forces all reset values asynchronously. Release is synchronous to the next clk edge.

## Test plan
- pat=1101, ovl=1, thresh=0; stream 0,1,1,1,0,1,1,0,1 one bit per cycle -> match pulses after bits 6 and 9; match_cnt=2; state stays RUN.
- Same stream with ovl=0 -> a single match after bit 6; match_cnt=1.
- pat=1101, ovl=1, thresh=3; stream 1,1,0,1,1,0,1,1,0,1 -> matches after bits 4, 7 and 10; DONE after bit 10; done=1, in_ready=0; further in_valid is ignored; start restarts with match_cnt=0.
- Same stream, ovl=0, thresh=0 -> matches after bits 4 and 10; match_cnt=2.
- cfg_we with pat=0011 during RUN -> ignored, 1101 is still detected. stop and start together in RUN -> IDLE with match_cnt held. cfg_we in IDLE then loads.
- rst low mid-run, after 3 bits of 1101 -> all outputs are at reset values at once; after release and start, a 1-bit tail does not complete a match.

Source files
------------

// File: rtl/seq_det_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_det_ctrl                                                 |
// | Description : Run controller with a programmable serial pattern detector,  |
// |               overlap/non-overlap modes, match counter and threshold stop. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seq_det_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic             cfg_ovl,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done,
  output logic             busy,
  output logic [1:0]       state
);

  localparam int                  c_fill_w  = $clog2(PAT_W + 1);
  localparam logic [c_fill_w-1:0] c_full    = c_fill_w'(PAT_W);
  localparam logic [CNT_W-1:0]    c_cnt_max = '1;

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_run  = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [PAT_W-1:0]    r_pat;
  logic                r_ovl;
  logic [CNT_W-1:0]    r_thresh;
  logic [PAT_W-1:0]    r_hist;
  logic [c_fill_w-1:0] r_fill;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_match;

  logic                w_acc;
  logic                w_clr;
  logic                w_cfg_ld;
  logic                w_hit;
  logic [PAT_W-1:0]    w_hist_nxt;
  logic [c_fill_w-1:0] w_fill_inc;
  logic [CNT_W-1:0]    w_cnt_inc;

  assign w_acc      = in_valid && (r_state == c_run);
  assign w_clr      = start && !stop && ((r_state == c_idle) || (r_state == c_done));
  assign w_cfg_ld   = cfg_we && (r_state == c_idle);
  assign w_hist_nxt = {r_hist[PAT_W-2:0], in_bit};
  assign w_fill_inc = (r_fill == c_full) ? c_full : r_fill + 1'b1;
  assign w_cnt_inc  = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;
  assign w_hit      = w_acc && (w_fill_inc == c_full) && (w_hist_nxt == r_pat);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_idle;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; stop always wins over start
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle: if (start && !stop) w_state_nxt = c_run;
      c_run: begin
        if (stop)
          w_state_nxt = c_idle;
        else if (w_hit && (r_thresh != '0) && (w_cnt_inc == r_thresh))
          w_state_nxt = c_done;
      end
      c_done: begin
        if (stop)       w_state_nxt = c_idle;
        else if (start) w_state_nxt = c_run;
      end
      default: w_state_nxt = c_idle;
    endcase
  end

  // Status outputs decode the state register directly
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      c_run: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      c_done:  done = 1'b1;
      default: ;
    endcase
  end

  // Config, detector history and match counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pat    <= '0;
      r_ovl    <= 1'b1;
      r_thresh <= '0;
      r_hist   <= '0;
      r_fill   <= '0;
      r_cnt    <= '0;
      r_match  <= 1'b0;
    end else begin
      r_match <= w_hit;
      if (w_cfg_ld) begin
        r_pat    <= cfg_pat;
        r_ovl    <= cfg_ovl;
        r_thresh <= cfg_thresh;
      end
      if (w_clr) begin
        r_hist <= '0;
        r_fill <= '0;
        r_cnt  <= '0;
      end else if (w_acc) begin
        r_hist <= w_hist_nxt;
        // Non-overlap keeps hist but demands PAT_W fresh bits before the next match
        r_fill <= (w_hit && !r_ovl) ? '0 : w_fill_inc;
        if (w_hit) r_cnt <= w_cnt_inc;
      end
    end
  end

  assign state     = r_state;
  assign match     = r_match;
  assign match_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seq_det_ctrl                                              |
// | Description : Scoreboard bench for seq_det_ctrl with a queue-based model.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seq_det_ctrl;
  localparam int PW = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [PW-1:0] cfg_pat;
  logic          cfg_ovl;
  logic [CW-1:0] cfg_thresh;
  logic          start;
  logic          stop;
  logic          in_valid;
  logic          in_bit;
  logic          in_ready;
  logic          match;
  logic [CW-1:0] match_cnt;
  logic          done;
  logic          busy;
  logic [1:0]    state;

  always #5 clk = ~clk;

  seq_det_ctrl #(.PAT_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_ovl(cfg_ovl),
    .cfg_thresh(cfg_thresh), .start(start), .stop(stop), .in_valid(in_valid),
    .in_bit(in_bit), .in_ready(in_ready), .match(match), .match_cnt(match_cnt),
    .done(done), .busy(busy), .state(state)
  );

  typedef struct packed {
    logic          m;
    logic [CW-1:0] c;
    logic [1:0]    s;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: bits since the last clear kept as a list
  int            mstate;
  logic [PW-1:0] mpat;
  logic          movl;
  logic [CW-1:0] mthr;
  int            mcnt;
  logic          seg[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mstate = 0; mpat = '0; movl = 1'b1; mthr = '0; mcnt = 0;
    seg.delete();
  endtask

  task automatic cyc(input logic v, input logic b, input logic st, input logic sp,
                     input logic we, input logic [PW-1:0] p, input logic o,
                     input logic [CW-1:0] th);
    logic          acc;
    logic          hit;
    logic [PW-1:0] tail;
    exp_t          e;
    in_valid = v; in_bit = b; start = st; stop = sp;
    cfg_we = we; cfg_pat = p; cfg_ovl = o; cfg_thresh = th;
    acc = v && (mstate == 1);
    hit = 1'b0;
    if (acc) begin
      seg.push_back(b);
      if (seg.size() >= PW) begin
        for (int i = 0; i < PW; i++) tail[PW-1-i] = seg[seg.size()-PW+i];
        hit = (tail == mpat);
      end
      if (hit) begin
        if (mcnt < (1 << CW) - 1) mcnt++;
        if (!movl) seg.delete();
      end
    end
    case (mstate)
      0: begin
        if (we) begin mpat = p; movl = o; mthr = th; end
        if (st && !sp) begin mstate = 1; mcnt = 0; seg.delete(); end
      end
      1: begin
        if (sp) mstate = 0;
        else if (hit && mthr != 0 && mcnt == int'(mthr)) mstate = 2;
      end
      default: begin
        if (sp) mstate = 0;
        else if (st) begin mstate = 1; mcnt = 0; seg.delete(); end
      end
    endcase
    if (acc) begin
      e.m = hit; e.c = mcnt[CW-1:0]; e.s = mstate[1:0];
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    chk("state", state, mstate);
    chk("match_cnt", match_cnt, mcnt);
    chk("in_ready", in_ready, mstate == 1);
    chk("busy", busy, mstate == 1);
    chk("done", done, mstate == 2);
  endtask

  task automatic idle();                      cyc(0, 0, 0, 0, 0, '0, 0, '0); endtask
  task automatic go();                        cyc(0, 0, 1, 0, 0, '0, 0, '0); endtask
  task automatic halt();                      cyc(0, 0, 0, 1, 0, '0, 0, '0); endtask
  task automatic bitv(input logic b);         cyc(1, b, 0, 0, 0, '0, 0, '0); endtask
  task automatic cfg(input logic [PW-1:0] p, input logic o, input logic [CW-1:0] th);
    cyc(0, 0, 0, 0, 1, p, o, th);
  endtask
  task automatic send(input logic [15:0] s, input int n);
    for (int i = n - 1; i >= 0; i--) bitv(s[i]);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_state", state, 0);
    chk("rst_match", match, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
  endtask

  // Monitor: pops one expectation per observed handshake
  initial begin : monitor
    logic pend;
    exp_t e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL mon_underflow: got handshake expected none at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            chk("mon_match", match, e.m);
            chk("mon_cnt", match_cnt, e.c);
            chk("mon_state", state, e.s);
          end
        end else begin
          chk("idle_match", match, 0);
        end
        pend = in_valid && in_ready;
      end
    end
  end

  initial begin : stim
    rst = 1'b0;
    in_valid = 0; in_bit = 0; start = 0; stop = 0;
    cfg_we = 0; cfg_pat = '0; cfg_ovl = 0; cfg_thresh = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs();
    rst = 1'b1;
    @(posedge clk); #1;

    // Overlap, unlimited; final bit arrives together with stop
    cfg(4'b1101, 1, 0); go();
    send(16'b01110110, 8);
    cyc(1, 1, 0, 1, 0, '0, 0, '0);
    idle();

    // Same stream, non-overlap
    cfg(4'b1101, 0, 0); go();
    send(16'b011101101, 9); halt();

    // Threshold 3 in overlap: DONE, extra bits dropped, restart clears count
    cfg(4'b1101, 1, 3); go();
    send(16'b1101101101, 10);
    send(16'b1101, 4);
    go(); send(16'b110, 3); halt();

    // Non-overlap, unlimited
    cfg(4'b1101, 0, 0); go();
    send(16'b1101101101, 10);

    // Config writes ignored while running; stop+start -> IDLE with count held
    cyc(0, 0, 0, 0, 1, 4'b0011, 1, 8'd1);
    send(16'b1101, 4);
    cyc(0, 0, 1, 1, 0, '0, 0, '0);
    idle();
    cfg(4'b0011, 1, 0); go(); send(16'b0011, 4); halt();

    // Asynchronous reset mid-run after three bits of 1101
    cfg(4'b1101, 1, 0); go(); send(16'b110, 3);
    in_valid = 0; start = 0; stop = 0; cfg_we = 0;
    rst = 1'b0;
    #1 chk_reset_outputs();
    model_reset();
    @(negedge clk);
    exp_q.delete();
    #2 rst = 1'b1;
    @(posedge clk); #1;
    go(); bitv(1'b1); send(16'b00000, 5); halt();

    // Counter saturation
    cfg(4'b1111, 1, 0); go();
    for (int i = 0; i < 300; i++) bitv(1'b1);
    halt();

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      cfg(4'($urandom), 1'($urandom), 8'($urandom_range(0, 5)));
      go();
      for (int k = 0; k < 80; k++) begin
        cyc($urandom_range(0, 3) != 0, 1'($urandom),
            $urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 19) == 0, 4'($urandom), 1'($urandom),
            8'($urandom_range(0, 5)));
      end
      halt();
    end

    idle(); idle();
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
